zigzag_rom_loader: RTL and testbench



---
 rtl/zigzag_pkg.sv | 30 +++
 rtl/rom_region_decode.sv | 36 +++
 rtl/zigzag_rom_loader.sv | 162 ++++++++++++++++
 tb/tb_zigzag_rom_loader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/zigzag_pkg.sv
// Shared constants and enums for the galaxian-family ROM download path.
// Region layout defaults match the zigzag image: CPU, then GFX, then colour PROM.
package zigzag_pkg;

  localparam int CPU_SIZE_DEF  = 16384;
  localparam int GFX_SIZE_DEF  = 4096;
  localparam int PROM_SIZE_DEF = 32;
  localparam int CPU_BASE_DEF  = 0;
  localparam int GFX_BASE_DEF  = CPU_BASE_DEF + CPU_SIZE_DEF;
  localparam int PROM_BASE_DEF = GFX_BASE_DEF + GFX_SIZE_DEF;
  localparam int TOTAL         = PROM_BASE_DEF + PROM_SIZE_DEF;
  localparam int COUNT_W       = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_HOLD,
    ST_READY,
    ST_ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    REGION_NONE,
    REGION_CPU,
    REGION_GFX,
    REGION_PROM
  } region_sel_t;

endpackage

// File: rtl/rom_region_decode.sv
// Combinational download-address decoder: picks the ROM region and the
// region-local address. Shared by the galaxian-family cores.
module rom_region_decode
  import zigzag_pkg::*;
#(
  parameter int CPU_SIZE  = CPU_SIZE_DEF,
  parameter int GFX_SIZE  = GFX_SIZE_DEF,
  parameter int PROM_SIZE = PROM_SIZE_DEF
) (
  input  logic [24:0]  addr,
  output region_sel_t  region,
  output logic [2:0]   region_oh,   // {prom, gfx, cpu}
  output logic [15:0]  local_addr
);

  localparam logic [24:0] GFX_BASE  = 25'(CPU_SIZE);
  localparam logic [24:0] PROM_BASE = 25'(CPU_SIZE + GFX_SIZE);
  localparam logic [24:0] END_ADDR  = 25'(CPU_SIZE + GFX_SIZE + PROM_SIZE);

  always_comb begin
    region     = REGION_NONE;
    local_addr = 16'(addr);
    if (addr < GFX_BASE) begin
      region     = REGION_CPU;
      local_addr = 16'(addr);
    end else if (addr < PROM_BASE) begin
      region     = REGION_GFX;
      local_addr = 16'(addr - GFX_BASE);
    end else if (addr < END_ADDR) begin
      region     = REGION_PROM;
      local_addr = 16'(addr - PROM_BASE);
    end
    region_oh = {region == REGION_PROM, region == REGION_GFX, region == REGION_CPU};
  end

endmodule

// File: rtl/zigzag_rom_loader.sv
// Steers the HPS ROM download into per-region write ports, verifies the image
// size and sums it, and keeps the core in reset until a good image is loaded.
module zigzag_rom_loader
  import zigzag_pkg::*;
#(
  parameter int CPU_SIZE   = CPU_SIZE_DEF,
  parameter int GFX_SIZE   = GFX_SIZE_DEF,
  parameter int PROM_SIZE  = PROM_SIZE_DEF,
  parameter int RESET_HOLD = 16
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_download,
  input  logic                ioctl_wr,
  input  logic [24:0]         ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  output logic                cpu_we,
  output logic                gfx_we,
  output logic                prom_we,
  output logic [15:0]         rom_addr,
  output logic [7:0]          rom_data,
  output logic                core_reset,
  output logic                rom_ready,
  output logic                load_error,
  output logic [COUNT_W-1:0]  byte_count,
  output logic [7:0]          checksum
);

  localparam logic [COUNT_W-1:0] TOTAL_COUNT = COUNT_W'(CPU_SIZE + GFX_SIZE + PROM_SIZE);
  localparam int                 HOLD_W      = $clog2(RESET_HOLD + 1) + 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'((RESET_HOLD > 0) ? RESET_HOLD - 1 : 0);

  loader_state_t      state_q, state_d;
  logic               dl_q;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [7:0]         sum_q, sum_d;
  logic               overflow_q, overflow_d;
  logic               load_error_q, load_error_d;
  logic [2:0]         we_q, we_d;
  logic [15:0]        rom_addr_q, rom_addr_d;
  logic [7:0]         rom_data_q, rom_data_d;
  logic               core_reset_q, core_reset_d;
  logic               rom_ready_q, rom_ready_d;

  region_sel_t region;
  logic [2:0]  region_oh;
  logic [15:0] local_addr;
  logic        dl_rise, dl_fall, accept;

  rom_region_decode #(
    .CPU_SIZE  (CPU_SIZE),
    .GFX_SIZE  (GFX_SIZE),
    .PROM_SIZE (PROM_SIZE)
  ) u_decode (
    .addr       (ioctl_addr),
    .region     (region),
    .region_oh  (region_oh),
    .local_addr (local_addr)
  );

  always_comb begin
    dl_rise = ioctl_download & ~dl_q;
    dl_fall = ~ioctl_download & dl_q;
    // A strobe coincident with the download dropping is deliberately discarded.
    accept  = (state_q == ST_LOAD) && ioctl_download && ioctl_wr;

    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    count_d      = count_q;
    sum_d        = sum_q;
    overflow_d   = overflow_q;
    load_error_d = load_error_q;
    we_d         = '0;
    rom_addr_d   = rom_addr_q;
    rom_data_d   = rom_data_q;

    if (dl_rise) begin
      state_d      = ST_LOAD;
      count_d      = '0;
      sum_d        = '0;
      overflow_d   = 1'b0;
      load_error_d = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (dl_fall) state_d = ST_CHECK;
          if (accept) begin
            rom_addr_d = local_addr;
            rom_data_d = ioctl_dout;
            we_d       = region_oh;
            if (region == REGION_NONE) begin
              overflow_d = 1'b1;
            end else begin
              if (count_q != '1) count_d = count_q + 1'b1;
              sum_d = sum_q + ioctl_dout;
            end
          end
        end
        ST_CHECK: begin
          if (count_q == TOTAL_COUNT && !overflow_q) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
          end else begin
            state_d      = ST_ERROR;
            load_error_d = 1'b1;
          end
        end
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) state_d = ST_READY;
          else hold_cnt_d = hold_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end

    rom_ready_d  = (state_d == ST_READY);
    core_reset_d = (state_d != ST_READY);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      dl_q         <= 1'b1;   // a download already running at reset release is ignored
      hold_cnt_q   <= '0;
      count_q      <= '0;
      sum_q        <= '0;
      overflow_q   <= 1'b0;
      load_error_q <= 1'b0;
      we_q         <= '0;
      rom_addr_q   <= '0;
      rom_data_q   <= '0;
      core_reset_q <= 1'b1;
      rom_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      dl_q         <= ioctl_download;
      hold_cnt_q   <= hold_cnt_d;
      count_q      <= count_d;
      sum_q        <= sum_d;
      overflow_q   <= overflow_d;
      load_error_q <= load_error_d;
      we_q         <= we_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
      core_reset_q <= core_reset_d;
      rom_ready_q  <= rom_ready_d;
    end
  end

  assign cpu_we     = we_q[0];
  assign gfx_we     = we_q[1];
  assign prom_we    = we_q[2];
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign core_reset = core_reset_q;
  assign rom_ready  = rom_ready_q;
  assign load_error = load_error_q;
  assign byte_count = count_q;
  assign checksum   = sum_q;

endmodule

// File: tb/tb_zigzag_rom_loader.sv
// Directed bench for zigzag_rom_loader: download sequencing, region steering,
// completeness/overflow checking and core reset timing.
module tb_zigzag_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b1;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        cpu_we, gfx_we, prom_we;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        core_reset, rom_ready, load_error;
  logic [16:0] byte_count;
  logic [7:0]  checksum;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk_sys = ~clk_sys;

  zigzag_rom_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .cpu_we         (cpu_we),
    .gfx_we         (gfx_we),
    .prom_we        (prom_we),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .core_reset     (core_reset),
    .rom_ready      (rom_ready),
    .load_error     (load_error),
    .byte_count     (byte_count),
    .checksum       (checksum)
  );

  // Write-port monitor; tasks compare deltas of these tallies.
  int          cpu_pulses = 0, gfx_pulses = 0, prom_pulses = 0;
  int          multi_hot = 0, data_bad = 0, prom_addr_sum = 0;
  logic [15:0] cpu_last = '0, gfx_last = '0, prom_last = '0;

  always @(negedge clk_sys) begin
    if ($countones({cpu_we, gfx_we, prom_we}) > 1) multi_hot <= multi_hot + 1;
    if ((cpu_we | gfx_we | prom_we) && rom_data !== rom_addr[7:0]) data_bad <= data_bad + 1;
    if (cpu_we) begin cpu_pulses <= cpu_pulses + 1; cpu_last <= rom_addr; end
    if (gfx_we) begin gfx_pulses <= gfx_pulses + 1; gfx_last <= rom_addr; end
    if (prom_we) begin
      prom_pulses   <= prom_pulses + 1;
      prom_last     <= rom_addr;
      prom_addr_sum <= prom_addr_sum + int'(rom_addr);
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_dl();
    ioctl_download = 1'b0;
    tick();
    ioctl_download = 1'b1;
    tick();
  endtask

  // Back-to-back strobes, data byte = global address low byte.
  task automatic write_range(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(base + i);
      ioctl_dout = 8'(base + i);
      tick();
    end
    ioctl_wr = 1'b0;
  endtask

  task automatic test_reset();
    int p0;
    repeat (3) tick();
    tests_run++; if (core_reset !== 1'b1) begin tests_failed++; $display("FAIL reset_core_reset: got %0b expected 1", core_reset); end
    tests_run++; if ({cpu_we, gfx_we, prom_we} !== 3'b000) begin tests_failed++; $display("FAIL reset_we: got %b expected 000", {cpu_we, gfx_we, prom_we}); end
    tests_run++; if ({rom_ready, load_error} !== 2'b00) begin tests_failed++; $display("FAIL reset_flags: got %b expected 00", {rom_ready, load_error}); end
    tests_run++; if (byte_count !== 17'h0 || checksum !== 8'h0) begin tests_failed++; $display("FAIL reset_counters: got %0h/%0h expected 0/0", byte_count, checksum); end
    tests_run++; if (rom_addr !== 16'h0 || rom_data !== 8'h0) begin tests_failed++; $display("FAIL reset_rom_bus: got %0h/%0h expected 0/0", rom_addr, rom_data); end
    reset = 1'b0;
    tick();
    p0 = cpu_pulses + gfx_pulses + prom_pulses;
    write_range(0, 8);
    tick();
    tests_run++; if (cpu_pulses + gfx_pulses + prom_pulses - p0 !== 0) begin tests_failed++; $display("FAIL stale_download_we: got %0d pulses expected 0", cpu_pulses + gfx_pulses + prom_pulses - p0); end
    tests_run++; if (byte_count !== 17'h0) begin tests_failed++; $display("FAIL stale_download_count: got %0h expected 0", byte_count); end
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_load();
    int p0;
    start_dl();
    write_range(0, 32'h1000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    p0 = cpu_pulses + gfx_pulses + prom_pulses;
    write_range(32'h1000, 64);
    tick();
    tests_run++; if (cpu_pulses + gfx_pulses + prom_pulses - p0 !== 0) begin tests_failed++; $display("FAIL midreset_we: got %0d pulses expected 0", cpu_pulses + gfx_pulses + prom_pulses - p0); end
    tests_run++; if (byte_count !== 17'h0) begin tests_failed++; $display("FAIL midreset_count: got %0h expected 0", byte_count); end
    ioctl_download = 1'b0;
    repeat (20) tick();
    tests_run++; if ({core_reset, rom_ready, load_error} !== 3'b100) begin tests_failed++; $display("FAIL midreset_idle: got %b expected 100", {core_reset, rom_ready, load_error}); end
  endtask

  task automatic test_full_image();
    int c0, g0, p0, m0, d0;
    logic [7:0] exp_sum;
    exp_sum = 8'h00;
    for (int i = 0; i < 32'h5020; i++) exp_sum = exp_sum + 8'(i);
    c0 = cpu_pulses; g0 = gfx_pulses; p0 = prom_pulses; m0 = multi_hot; d0 = data_bad;
    start_dl();
    write_range(0, 32'h5020);
    tick();
    tests_run++; if (byte_count !== 17'h5020) begin tests_failed++; $display("FAIL full_count: got %0h expected 5020", byte_count); end
    tests_run++; if (checksum !== exp_sum) begin tests_failed++; $display("FAIL full_checksum: got %0h expected %0h", checksum, exp_sum); end
    tests_run++; if (cpu_pulses - c0 !== 32'h4000 || cpu_last !== 16'h3FFF) begin tests_failed++; $display("FAIL full_cpu_we: got %0h pulses last %0h expected 4000 last 3fff", cpu_pulses - c0, cpu_last); end
    tests_run++; if (gfx_pulses - g0 !== 32'h1000 || gfx_last !== 16'h0FFF) begin tests_failed++; $display("FAIL full_gfx_we: got %0h pulses last %0h expected 1000 last fff", gfx_pulses - g0, gfx_last); end
    tests_run++; if (prom_pulses - p0 !== 32'h20 || prom_last !== 16'h001F) begin tests_failed++; $display("FAIL full_prom_we: got %0h pulses last %0h expected 20 last 1f", prom_pulses - p0, prom_last); end
    tests_run++; if (multi_hot - m0 !== 0 || data_bad - d0 !== 0) begin tests_failed++; $display("FAIL full_bus_integrity: got %0d multi-hot %0d bad data expected 0/0", multi_hot - m0, data_bad - d0); end
    ioctl_download = 1'b0;
    repeat (17) tick();
    tests_run++; if ({rom_ready, core_reset} !== 2'b01) begin tests_failed++; $display("FAIL full_hold_17: got ready/reset %b expected 01", {rom_ready, core_reset}); end
    tick();
    tests_run++; if ({rom_ready, core_reset, load_error} !== 3'b100) begin tests_failed++; $display("FAIL full_ready_18: got ready/reset/err %b expected 100", {rom_ready, core_reset, load_error}); end
  endtask

  task automatic test_second_truncated();
    ioctl_download = 1'b1;
    tick();
    tests_run++; if (core_reset !== 1'b1 || rom_ready !== 1'b0) begin tests_failed++; $display("FAIL redl_core_reset: got reset/ready %b expected 10", {core_reset, rom_ready}); end
    tests_run++; if (byte_count !== 17'h0 || checksum !== 8'h0) begin tests_failed++; $display("FAIL redl_clear: got %0h/%0h expected 0/0", byte_count, checksum); end
    write_range(0, 32'h5000);
    ioctl_download = 1'b0;
    repeat (20) tick();
    tests_run++; if (byte_count !== 17'h5000) begin tests_failed++; $display("FAIL trunc_count: got %0h expected 5000", byte_count); end
    tests_run++; if ({load_error, rom_ready, core_reset} !== 3'b101) begin tests_failed++; $display("FAIL trunc_flags: got err/ready/reset %b expected 101", {load_error, rom_ready, core_reset}); end
  endtask

  task automatic test_overflow();
    start_dl();
    write_range(0, 32'h5020);
    ioctl_wr = 1'b1; ioctl_addr = 25'h6000; ioctl_dout = 8'h5A;
    tick();
    ioctl_wr = 1'b0;
    tests_run++; if ({cpu_we, gfx_we, prom_we} !== 3'b000) begin tests_failed++; $display("FAIL ovf_we: got %b expected 000", {cpu_we, gfx_we, prom_we}); end
    tests_run++; if (byte_count !== 17'h5020) begin tests_failed++; $display("FAIL ovf_count: got %0h expected 5020", byte_count); end
    ioctl_download = 1'b0;
    repeat (20) tick();
    tests_run++; if ({load_error, rom_ready, core_reset} !== 3'b101) begin tests_failed++; $display("FAIL ovf_flags: got err/ready/reset %b expected 101", {load_error, rom_ready, core_reset}); end
  endtask

  task automatic test_write_latency();
    start_dl();
    ioctl_wr = 1'b1; ioctl_addr = 25'h4005; ioctl_dout = 8'hA5;
    tick();
    ioctl_wr = 1'b0;
    tests_run++; if ({cpu_we, gfx_we, prom_we} !== 3'b010) begin tests_failed++; $display("FAIL lat_we: got %b expected 010", {cpu_we, gfx_we, prom_we}); end
    tests_run++; if (rom_addr !== 16'h0005 || rom_data !== 8'hA5) begin tests_failed++; $display("FAIL lat_bus: got %0h/%0h expected 5/a5", rom_addr, rom_data); end
    tests_run++; if (byte_count !== 17'h1 || checksum !== 8'hA5) begin tests_failed++; $display("FAIL lat_counters: got %0h/%0h expected 1/a5", byte_count, checksum); end
    tick();
    tests_run++; if (gfx_we !== 1'b0) begin tests_failed++; $display("FAIL lat_one_cycle: got %0b expected 0", gfx_we); end
    ioctl_download = 1'b0;
    ioctl_wr = 1'b1; ioctl_addr = 25'h0010; ioctl_dout = 8'h10;
    tick();
    ioctl_wr = 1'b0;
    tests_run++; if (cpu_we !== 1'b0 || byte_count !== 17'h1) begin tests_failed++; $display("FAIL fall_write_dropped: got we %0b count %0h expected 0/1", cpu_we, byte_count); end
    repeat (2) tick();
    tests_run++; if (load_error !== 1'b1) begin tests_failed++; $display("FAIL lat_error: got %0b expected 1", load_error); end
  endtask

  task automatic test_back_to_back();
    int p0, s0, o0;
    start_dl();
    p0 = prom_pulses; s0 = prom_addr_sum; o0 = cpu_pulses + gfx_pulses;
    write_range(32'h5000, 32);
    tick();
    tests_run++; if (prom_pulses - p0 !== 32 || prom_last !== 16'h001F) begin tests_failed++; $display("FAIL burst_pulses: got %0d last %0h expected 32 last 1f", prom_pulses - p0, prom_last); end
    tests_run++; if (prom_addr_sum - s0 !== 496 || cpu_pulses + gfx_pulses - o0 !== 0) begin tests_failed++; $display("FAIL burst_addrs: got sum %0d other %0d expected 496/0", prom_addr_sum - s0, cpu_pulses + gfx_pulses - o0); end
    tests_run++; if (byte_count !== 17'd32 || checksum !== 8'hF0) begin tests_failed++; $display("FAIL burst_counters: got %0h/%0h expected 20/f0", byte_count, checksum); end
    ioctl_download = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_reset_mid_load();
    test_full_image();
    test_second_truncated();
    test_overflow();
    test_write_latency();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
